ula_flag_gen: RTL and testbench
===============================

# ula_flag_gen

Sequential flag generator: the producer side of the ALU comparison flag interface. It accepts two operands over a valid/ready handshake and subtracts them bit-serially, LSB first, one bit per clock. It then presents registered zero, sign, carry and overflow flags over a second valid/ready handshake. Downstream equality, greater-or-equal and less-or-equal comparison blocks consume `zero_flag` and `sign_flag` directly.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: operands valid.
- `req_ready` out 1: block can accept operands.
- `op_a` in WIDTH: minuend.
- `op_b` in WIDTH: subtrahend.
- `signed_mode` in 1: 1 selects two's-complement compare (present only with `ULA_FLAGS_SIGNED_EN`).
- `flags_valid` out 1: flag result available.
- `flags_ready` in 1: consumer takes the result.
- `zero_flag` out 1: 1 when op_a == op_b.
- `sign_flag` out 1: 1 when op_a < op_b in the selected mode.
- `carry_flag` out 1: 1 when no borrow occurs (op_a ≥ op_b unsigned).
- `overflow_flag` out 1: two's-complement overflow of op_a − op_b.

## Operation
- Computes op_a + ~op_b + 1, serially.
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch op_a, op_b and `signed_mode` into shift registers, clear the bit counter, set carry=1 and diff_or=0, then go to SHIFT.
  - SHIFT: each cycle:
    - d = a[0] ^ ~b[0] ^ c; c ← majority(a[0], ~b[0], c); diff_or ← diff_or | d.
    - Shift a and b right and increment the counter.
    - Also track the MSB bits a_msb, b_msb and the last d, captured when count == WIDTH−1.
    - On the WIDTH-th SHIFT cycle, write the flag register and go to DONE.
  - DONE: `flags_valid`=1. When `flags_ready`=1, go to IDLE.
- Flag equations, evaluated at the final bit:
  - zero = ~(diff_or | d).
  - carry = c_out.
  - N = d.
  - V = (a_msb ≠ b_msb) & (d ≠ a_msb).
  - sign = signed_mode ? (N ^ V) : ~c_out.
- Flag outputs are registered. They hold their last value through IDLE and SHIFT and change only on the DONE entry edge.
- Operand inputs are ignored outside the IDLE accept edge. `req_valid` during SHIFT or DONE is not accepted and must be held by the source.
- Reset mid-operation (any state): abort immediately, discard partial state, and go to IDLE.
- Reset values: `req_ready`=1, `flags_valid`=0, all four flags=0, state=IDLE, counter=0.

## Timing
- Accept edge: IDLE with req_valid & req_ready.
- `flags_valid` rises exactly WIDTH cycles after the accept edge, i.e. 8 cycles at WIDTH=8.
- `flags_valid` stays high, with flags stable, until a cycle with `flags_ready`=1. The following edge returns to IDLE.
- `req_ready` is combinational from state (IDLE only). It never depends on `req_valid`.
- No overlap between operations. With `flags_ready` tied high, throughput is one operation per WIDTH+2 cycles.
- `flags_ready` asserted before DONE has no effect.

## Configuration
- `ULA_FLAGS_SIGNED_EN`
  - Defined: the `signed_mode` port exists, `overflow_flag` is computed, and `sign_flag` follows the signed/unsigned selection.
  - Undefined: no `signed_mode` port, operation is unsigned only, `sign_flag` = ~c_out, and `overflow_flag` is constant 0.

## Structure
- Shared package `ula_pkg`:
  - `ULA_WIDTH` = 8 constant.
  - State enum typedef (IDLE, SHIFT, DONE).
  - Packed flag struct typedef {zero, sign, carry, overflow}.
- One sub-module, `ula_sub_bit`: combinational 1-bit full subtractor cell taking (a, b, c_in) and returning (d, c_out), instantiated once.

## Test plan
All scenarios use WIDTH=8.
1. Equal operands: a=0x05, b=0x05 → zero=1, sign=0, carry=1, overflow=0. `flags_valid` rises 8 cycles after the accept edge.
2. Unsigned less: a=0x03, b=0x80, unsigned → zero=0, sign=1, carry=0.
3. Signed overflow (macro on): a=0x80, b=0x01.
   - signed_mode=1 → overflow=1, sign=1.
   - signed_mode=0 → overflow=1, sign=0, carry=1.
4. Signed greater with overflow: a=0x7F, b=0xFF.
   - signed_mode=1 → overflow=1, sign=0.
   - Unsigned → carry=0, sign=1.
5. Backpressure: `flags_ready`=0 for 5 cycles with `req_valid`=1 and new operands applied.
   - `flags_valid` and the flags stay constant; `req_ready`=0 throughout.
   - After `flags_ready`, the next operation is accepted and returns correct flags.
6. Reset mid-operation: assert `rst_n`=0 on the 4th SHIFT cycle.
   - All outputs take their reset values asynchronously and `req_ready`=1.
   - After release, a=0x10, b=0x20 → sign=1, zero=0.

Source files
------------

// File: rtl/ula_flag_gen_pkg.sv
// ula_pkg: types and constants shared by the ula_flag_gen block.
//   ULA_WIDTH : default operand width.
//   state_e   : sequencer states (IDLE, SHIFT, DONE).
//   flags_t   : registered flag bundle {zero, sign, carry, overflow}.
package ula_pkg;

    localparam int ULA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/ula_flag_gen_if.sv
// ula_flag_gen_if: operand request handshake and flag result handshake.
//   master : requester side (drives operands and flags_ready).
//   slave  : flag generator side (drives req_ready, flags_valid and flags).
// Optional macro ULA_FLAGS_SIGNED_EN adds the signed_mode request field.
interface ula_flag_gen_if import ula_pkg::*; #(
    parameter int WIDTH = ULA_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef ULA_FLAGS_SIGNED_EN
    logic             signed_mode;
`endif
    logic             flags_valid;
    logic             flags_ready;
    logic             zero_flag;
    logic             sign_flag;
    logic             carry_flag;
    logic             overflow_flag;

`ifdef ULA_FLAGS_SIGNED_EN
    modport master (
        output req_valid, op_a, op_b, signed_mode, flags_ready,
        input  req_ready, flags_valid, zero_flag, sign_flag, carry_flag, overflow_flag
    );
    modport slave (
        input  req_valid, op_a, op_b, signed_mode, flags_ready,
        output req_ready, flags_valid, zero_flag, sign_flag, carry_flag, overflow_flag
    );
`else
    modport master (
        output req_valid, op_a, op_b, flags_ready,
        input  req_ready, flags_valid, zero_flag, sign_flag, carry_flag, overflow_flag
    );
    modport slave (
        input  req_valid, op_a, op_b, flags_ready,
        output req_ready, flags_valid, zero_flag, sign_flag, carry_flag, overflow_flag
    );
`endif

endinterface

// File: rtl/ula_flag_gen_sub_bit.sv
// ula_sub_bit: combinational 1-bit subtractor cell computing a + ~b + c_in.
//   a, b  : operand bits.
//   c_in  : incoming carry (1 = no borrow so far).
//   d     : difference bit.
//   c_out : outgoing carry.
module ula_sub_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic d,
    output logic c_out
);
    logic nb;

    assign nb    = ~b;
    assign d     = a ^ nb ^ c_in;
    assign c_out = (a & nb) | (a & c_in) | (nb & c_in);

endmodule

// File: rtl/ula_flag_gen.sv
// ula_flag_gen: bit-serial subtractor producing zero/sign/carry/overflow flags.
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus        : ula_flag_gen_if slave modport (operand request, flag result).
// Optional macro ULA_FLAGS_SIGNED_EN: enables signed_mode and overflow_flag;
// without it the compare is unsigned only and overflow_flag is tied to 0.
//
// state | meaning
// IDLE  | req_ready high, waiting for operands
// SHIFT | one operand bit subtracted per cycle, LSB first
// DONE  | flags_valid high until flags_ready
module ula_flag_gen import ula_pkg::*; #(
    parameter int WIDTH = ULA_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    ula_flag_gen_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             diff_or_q;
    flags_t           flags_q;
    flags_t           flags_next;
    logic             d;
    logic             c_next;
    logic             last_bit;
`ifdef ULA_FLAGS_SIGNED_EN
    logic             smode_q;
    logic             ovf;
`endif

    ula_sub_bit u_sub_bit (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (c_q),
        .d     (d),
        .c_out (c_next)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef ULA_FLAGS_SIGNED_EN
    // On the last bit a_sr[0]/b_sr[0] are the operand MSBs and d is the result MSB.
    assign ovf = (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif

    always_comb begin
        flags_next.zero  = ~(diff_or_q | d);
        flags_next.carry = c_next;
`ifdef ULA_FLAGS_SIGNED_EN
        flags_next.overflow = ovf;
        flags_next.sign     = smode_q ? (d ^ ovf) : ~c_next;
`else
        flags_next.overflow = 1'b0;
        flags_next.sign     = ~c_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            cnt_q     <= '0;
            c_q       <= 1'b1;
            diff_or_q <= 1'b0;
            flags_q   <= '0;
`ifdef ULA_FLAGS_SIGNED_EN
            smode_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        a_sr      <= bus.op_a;
                        b_sr      <= bus.op_b;
`ifdef ULA_FLAGS_SIGNED_EN
                        smode_q   <= bus.signed_mode;
`endif
                        cnt_q     <= '0;
                        c_q       <= 1'b1;
                        diff_or_q <= 1'b0;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    c_q       <= c_next;
                    diff_or_q <= diff_or_q | d;
                    a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
                    cnt_q     <= cnt_q + CW'(1);
                    if (last_bit) begin
                        flags_q <= flags_next;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.flags_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.flags_valid   = (state_q == S_DONE);
    assign bus.zero_flag     = flags_q.zero;
    assign bus.sign_flag     = flags_q.sign;
    assign bus.carry_flag    = flags_q.carry;
    assign bus.overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_ula_flag_gen.sv
// Testbench for ula_flag_gen at WIDTH=8 (signed cases exercised when
// ULA_FLAGS_SIGNED_EN is defined, otherwise the same operands run unsigned).
module tb_ula_flag_gen;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    flags_t exp_q[$];
    flags_t last_exp;

    always #5 clk = ~clk;

    ula_flag_gen_if #(.WIDTH(8)) bus ();

    ula_flag_gen #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic flags_t model(logic [7:0] a, logic [7:0] b, logic sm);
        flags_t f;
        logic [7:0] diff;
        diff    = a - b;
        f.zero  = (a == b);
        f.carry = (a >= b);
`ifdef ULA_FLAGS_SIGNED_EN
        f.overflow = (a[7] != b[7]) && (diff[7] != a[7]);
        f.sign     = sm ? ($signed(a) < $signed(b)) : (a < b);
`else
        f.overflow = 1'b0;
        f.sign     = (a < b) | (sm & 1'b0) | (diff[0] & 1'b0);
`endif
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input flags_t e);
        chk({tag, ".zero"},     32'(bus.zero_flag),     32'(e.zero));
        chk({tag, ".sign"},     32'(bus.sign_flag),     32'(e.sign));
        chk({tag, ".carry"},    32'(bus.carry_flag),    32'(e.carry));
        chk({tag, ".overflow"}, 32'(bus.overflow_flag), 32'(e.overflow));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sm);
        bus.op_a = a;
        bus.op_b = b;
`ifdef ULA_FLAGS_SIGNED_EN
        bus.signed_mode = sm;
`endif
        bus.req_valid = 1'b1;
    endtask

    // Drives a request, pushes its expected flags, and returns after the accept edge.
    task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm);
        int n;
        drive(a, b, sm);
        exp_q.push_back(model(a, b, sm));
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, ".ready_timeout"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.flags_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'd8);
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            last_exp = exp_q.pop_front();
            chk_flags(tag, last_exp);
        end
    endtask

    task automatic release_result();
        bus.flags_ready = 1'b1;
        tick();
        bus.flags_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.flags_ready = 1'b0;
`ifdef ULA_FLAGS_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif
        #12;
        chk("rst.req_ready",   32'(bus.req_ready),   32'd1);
        chk("rst.flags_valid", 32'(bus.flags_valid), 32'd0);
        chk_flags("rst", '0);
        rst_n = 1'b1;
        tick();

        // Equal operands, flags_ready held high early: must not shorten latency.
        bus.flags_ready = 1'b1;
        issue("eq", 8'h05, 8'h05, 1'b0);
        wait_result("eq");
        tick();
        chk("eq.back_idle", 32'(bus.req_ready), 32'd1);
        bus.flags_ready = 1'b0;

        issue("ult", 8'h03, 8'h80, 1'b0);
        wait_result("ult");
        release_result();

        issue("ovf_s", 8'h80, 8'h01, 1'b1);
        wait_result("ovf_s");
        release_result();
        issue("ovf_u", 8'h80, 8'h01, 1'b0);
        wait_result("ovf_u");
        release_result();

        issue("gt_s", 8'h7F, 8'hFF, 1'b1);
        wait_result("gt_s");
        release_result();
        issue("gt_u", 8'h7F, 8'hFF, 1'b0);
        wait_result("gt_u");

        // Backpressure: result held for 5 cycles while a new request waits.
        drive(8'hC8, 8'h37, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.flags_valid", 32'(bus.flags_valid), 32'd1);
            chk("bp.req_ready",   32'(bus.req_ready),   32'd0);
            chk_flags("bp.hold", last_exp);
        end
        release_result();
        issue("bp_next", 8'hC8, 8'h37, 1'b1);
        wait_result("bp_next");
        release_result();

        issue("pre_rst", 8'hF0, 8'h0F, 1'b0);
        wait_result("pre_rst");
        release_result();

        // Reset during the 4th SHIFT cycle.
        issue("abort", 8'h33, 8'h11, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.req_ready",   32'(bus.req_ready),   32'd1);
        chk("abort.flags_valid", 32'(bus.flags_valid), 32'd0);
        chk_flags("abort", '0);
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        tick();

        issue("post_rst", 8'h10, 8'h20, 1'b0);
        wait_result("post_rst");
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
